// File: rtl/gray_counter_n.sv
// gray_counter_n: parametrised up/down Gray-code counter with Gray-coded load,
// wrap or saturate behaviour at the extremes, sticky overflow/underflow flags
// and a one-cycle wrap pulse. All outputs come straight from registers.
module gray_counter_n #(
  parameter int WIDTH    = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Dir,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadGray,
  input  logic             ClrFlags,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] Binary,
  output logic             Overflow,
  output logic             Underflow,
  output logic             Wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_ovf;
  logic             r_unf;
  logic             r_wrap;

  logic [WIDTH-1:0] w_load_bin;
  logic [WIDTH-1:0] w_next_bin;
  logic [WIDTH-1:0] w_next_gray;
  logic             w_set_ovf;
  logic             w_set_unf;
  logic             w_wrap;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_load_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_load_bin[i] = ^(LoadGray >> i);
    end
  end

  // Next binary count, flag-set events and wrap pulse; load beats count beats hold.
  always_comb begin
    w_next_bin = r_bin;
    w_set_ovf  = 1'b0;
    w_set_unf  = 1'b0;
    w_wrap     = 1'b0;
    if (Load) begin
      w_next_bin = w_load_bin;
    end else if (En) begin
      if (Dir) begin
        if (r_bin == MAX_VAL) begin
          w_set_ovf = 1'b1;
          if (!SATURATE) begin
            w_next_bin = '0;
            w_wrap     = 1'b1;
          end
        end else begin
          w_next_bin = r_bin + 1'b1;
        end
      end else begin
        if (r_bin == '0) begin
          w_set_unf = 1'b1;
          if (!SATURATE) begin
            w_next_bin = MAX_VAL;
            w_wrap     = 1'b1;
          end
        end else begin
          w_next_bin = r_bin - 1'b1;
        end
      end
    end
    w_next_gray = w_next_bin ^ (w_next_bin >> 1);
  end

  // State register: count, its Gray image, sticky flags (set wins over clear) and wrap pulse.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_bin  <= '0;
      r_gray <= '0;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      r_bin  <= w_next_bin;
      r_gray <= w_next_gray;
      r_ovf  <= w_set_ovf | (r_ovf & ~ClrFlags);
      r_unf  <= w_set_unf | (r_unf & ~ClrFlags);
      r_wrap <= w_wrap;
    end
  end

  assign Output    = r_gray;
  assign Binary    = r_bin;
  assign Overflow  = r_ovf;
  assign Underflow = r_unf;
  assign Wrap      = r_wrap;

endmodule

// File: tb/tb_gray_counter_n.sv
// tb_gray_counter_n: three counters (3-bit wrap, 3-bit saturate, 5-bit wrap)
// share one stimulus stream; a counting model predicts each of them.
module tb_gray_counter_n;

  localparam int ND = 3;
  localparam int EW = 20; // {hamming_check, wrap, unf, ovf, bin[7:0], out[7:0]}

  // ---------------- clock / reset ----------------
  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       En = 1'b0;
  logic       Dir = 1'b0;
  logic       Load = 1'b0;
  logic [4:0] LoadGray = '0;
  logic       ClrFlags = 1'b0;

  always #5 Clk = ~Clk;

  logic [2:0] out_a, bin_a, out_b, bin_b;
  logic [4:0] out_c, bin_c;
  logic       ovf_a, unf_a, wrap_a, ovf_b, unf_b, wrap_b, ovf_c, unf_c, wrap_c;

  gray_counter_n #(.WIDTH(3), .SATURATE(1'b0)) dut_a (
    .Clk(Clk), .Reset(Reset), .En(En), .Dir(Dir), .Load(Load),
    .LoadGray(LoadGray[2:0]), .ClrFlags(ClrFlags),
    .Output(out_a), .Binary(bin_a), .Overflow(ovf_a), .Underflow(unf_a), .Wrap(wrap_a));

  gray_counter_n #(.WIDTH(3), .SATURATE(1'b1)) dut_b (
    .Clk(Clk), .Reset(Reset), .En(En), .Dir(Dir), .Load(Load),
    .LoadGray(LoadGray[2:0]), .ClrFlags(ClrFlags),
    .Output(out_b), .Binary(bin_b), .Overflow(ovf_b), .Underflow(unf_b), .Wrap(wrap_b));

  gray_counter_n #(.WIDTH(5), .SATURATE(1'b0)) dut_c (
    .Clk(Clk), .Reset(Reset), .En(En), .Dir(Dir), .Load(Load),
    .LoadGray(LoadGray), .ClrFlags(ClrFlags),
    .Output(out_c), .Binary(bin_c), .Overflow(ovf_c), .Underflow(unf_c), .Wrap(wrap_c));

  logic [EW-1:0] act [ND];
  assign act[0] = {1'b0, wrap_a, unf_a, ovf_a, 5'b0, bin_a, 5'b0, out_a};
  assign act[1] = {1'b0, wrap_b, unf_b, ovf_b, 5'b0, bin_b, 5'b0, out_b};
  assign act[2] = {1'b0, wrap_c, unf_c, ovf_c, 3'b0, bin_c, 3'b0, out_c};

  // ---------------- reference model ----------------
  int unsigned   m_width [ND] = '{3, 3, 5};
  bit            m_sat   [ND] = '{1'b0, 1'b1, 1'b0};
  int unsigned   m_cnt   [ND];
  bit            m_ovf   [ND];
  bit            m_unf   [ND];

  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  logic [EW-1:0] exp_q2[$];

  int n_vec = 0;
  int n_mis = 0;

  function automatic int unsigned gray_of(input int unsigned v);
    return v ^ (v >> 1);
  endfunction

  // Find the count whose Gray code matches the load word (search, not formula).
  function automatic int unsigned count_of_gray(input int unsigned g, input int unsigned w);
    int unsigned r = 0;
    for (int unsigned v = 0; v < (1 << w); v++) begin
      if (gray_of(v) == g) r = v;
    end
    return r;
  endfunction

  task automatic model_step(input int d);
    int unsigned maxv = (1 << m_width[d]) - 1;
    int unsigned prev = m_cnt[d];
    bit wrap = 0;
    bit set_o = 0;
    bit set_u = 0;
    bit ham = 0;
    logic [EW-1:0] e;
    if (!Reset) begin
      m_cnt[d] = 0; m_ovf[d] = 0; m_unf[d] = 0;
    end else begin
      if (Load) begin
        m_cnt[d] = count_of_gray(LoadGray & maxv, m_width[d]);
      end else if (En) begin
        if (Dir) begin
          if (prev == maxv) begin
            set_o = 1;
            if (!m_sat[d]) begin m_cnt[d] = 0; wrap = 1; end
          end else m_cnt[d] = prev + 1;
        end else begin
          if (prev == 0) begin
            set_u = 1;
            if (!m_sat[d]) begin m_cnt[d] = maxv; wrap = 1; end
          end else m_cnt[d] = prev - 1;
        end
        ham = (m_cnt[d] != prev);
      end
      m_ovf[d] = set_o ? 1'b1 : (ClrFlags ? 1'b0 : m_ovf[d]);
      m_unf[d] = set_u ? 1'b1 : (ClrFlags ? 1'b0 : m_unf[d]);
    end
    e = {ham, wrap, m_unf[d], m_ovf[d], 8'(m_cnt[d]), 8'(gray_of(m_cnt[d]))};
    case (d)
      0: exp_q0.push_back(e);
      1: exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit rst_n, input bit en, input bit dir, input bit ld,
                       input logic [4:0] lg, input bit clr);
    @(negedge Clk);
    Reset = rst_n; En = en; Dir = dir; Load = ld; LoadGray = lg; ClrFlags = clr;
    for (int d = 0; d < ND; d++) model_step(d);
  endtask

  task automatic run_n(input int n, input bit en, input bit dir);
    for (int i = 0; i < n; i++) drive(1'b1, en, dir, 1'b0, 5'd0, 1'b0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [7:0] prev_out [ND];

  always @(posedge Clk) begin
    #1;
    for (int d = 0; d < ND; d++) begin
      logic [EW-1:0] e;
      bit have;
      have = 0;
      e = '0;
      case (d)
        0: if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1; end
        1: if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1; end
        default: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); have = 1; end
      endcase
      if (have) begin
        n_vec++;
        if (act[d][EW-2:0] !== e[EW-2:0]) begin
          n_mis++;
          $display("FAIL state dut%0d t=%0t: got wrap/unf/ovf/bin/out=%b/%b/%b/%h/%h want %b/%b/%b/%h/%h",
                   d, $time, act[d][18], act[d][17], act[d][16], act[d][15:8], act[d][7:0],
                   e[18], e[17], e[16], e[15:8], e[7:0]);
        end
        if (e[EW-1]) begin
          n_vec++;
          if ($countones(act[d][7:0] ^ prev_out[d]) != 1) begin
            n_mis++;
            $display("FAIL hamming dut%0d t=%0t: %h -> %h, want exactly one bit change",
                     d, $time, prev_out[d], act[d][7:0]);
          end
        end
        prev_out[d] = act[d][7:0];
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int d = 0; d < ND; d++) begin
      m_cnt[d] = 0; m_ovf[d] = 0; m_unf[d] = 0; prev_out[d] = '0;
    end
    // Reset, then a full up-cycle of the 3-bit counter with its wrap.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    run_n(9, 1'b1, 1'b1);
    // Down through zero, then two more down steps.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    run_n(3, 1'b1, 1'b0);
    // Load beats enable; then count up twice.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 5'b00110, 1'b0);
    run_n(2, 1'b1, 1'b1);
    // Load the 3-bit max, push up into it three times; then hold at zero going down.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'b00100, 1'b0);
    run_n(3, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'b00000, 1'b0);
    run_n(2, 1'b1, 1'b0);
    // Flag clear colliding with a new overflow, then a plain clear.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'b00100, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'b00100, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1);
    run_n(2, 1'b0, 1'b1);
    // Reset while counting with load and enable high.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'b00011, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 5'b00111, 1'b0);
    // Full 5-bit up-cycle plus a couple of extra steps.
    run_n(34, 1'b1, 1'b1);
    // Direction flipping every cycle.
    for (int i = 0; i < 12; i++) drive(1'b1, 1'b1, i[0], 1'b0, 5'd0, 1'b0);
    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0), 1'($urandom),
            ($urandom_range(0, 7) == 0), 5'($urandom), ($urandom_range(0, 9) == 0));
    end
    // Drain the scoreboard.
    @(negedge Clk);
    @(negedge Clk);
    if (exp_q0.size() + exp_q1.size() + exp_q2.size() != 0) begin
      n_mis++;
      $display("FAIL drain: %0d expectations left, want 0",
               exp_q0.size() + exp_q1.size() + exp_q2.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
